// File: rtl/prbs16_checker.sv
// Serial PRBS-16 checker (x^16+x^14+x^13+x^11+1): self-synchronising search, verify, lock, error count.
// Define PRBS_CHK_LOSS_EN to compile in windowed lock-loss detection.
module prbs16_checker #(
  parameter int ERR_CNT_W   = 16,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 in_bit,
  input  logic                 resync,
  input  logic                 clear_count,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  if (WINDOW < 16 || (WINDOW & (WINDOW - 1)) != 0 || LOSS_THRESH < 1 || LOSS_THRESH > WINDOW)
  begin : g_param_check
    $error("prbs16_checker: illegal WINDOW/LOSS_THRESH");
  end

  logic [1:0]  state, state_nxt;
  logic [15:0] s, s_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        p, mism, count_err;

  assign p    = s[15] ^ s[13] ^ s[12] ^ s[10];
  assign mism = in_bit ^ p;

`ifdef PRBS_CHK_LOSS_EN
  localparam int WIN_W  = $clog2(WINDOW);
  localparam int WERR_W = $clog2(LOSS_THRESH + 1);

  logic [WIN_W-1:0]  win, win_nxt;
  logic [WERR_W-1:0] werr, werr_nxt, werr_inc;
`endif

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    cnt_nxt   = cnt;
    count_err = 1'b0;
`ifdef PRBS_CHK_LOSS_EN
    win_nxt   = win;
    werr_nxt  = werr;
    werr_inc  = werr + WERR_W'(mism);
`endif
    if (resync) begin
      state_nxt = SEARCH;
      cnt_nxt   = '0;
`ifdef PRBS_CHK_LOSS_EN
      win_nxt   = '0;
      werr_nxt  = '0;
`endif
    end else if (enable) begin
      case (state)
        SEARCH: begin
          // cnt wraps to 0 after the 16th bit, which doubles as the cleared verify count
          s_nxt   = {s[14:0], in_bit};
          cnt_nxt = cnt + 4'd1;
          if (cnt == 4'd15 && s_nxt != '0) state_nxt = VERIFY;
        end
        VERIFY: begin
          s_nxt = {s[14:0], in_bit};
          if (mism) begin
            state_nxt = SEARCH;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 4'd1;
            if (cnt == 4'd15) state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          // local state free-runs on its own prediction so a flipped bit costs one err only
          s_nxt     = {s[14:0], p};
          count_err = mism;
`ifdef PRBS_CHK_LOSS_EN
          if (mism && werr_inc >= WERR_W'(LOSS_THRESH)) begin
            state_nxt = SEARCH;
            cnt_nxt   = '0;
            win_nxt   = '0;
            werr_nxt  = '0;
          end else begin
            win_nxt  = win + 1'b1;
            werr_nxt = (win == WIN_W'(WINDOW - 1)) ? '0 : werr_inc;
          end
`endif
        end
        default: begin
          state_nxt = SEARCH;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      s         <= '0;
      cnt       <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      state  <= state_nxt;
      s      <= s_nxt;
      cnt    <= cnt_nxt;
      locked <= (state_nxt == LOCKED);
      err    <= count_err;
      if (clear_count)
        err_count <= '0;
      else if (count_err && err_count != '1)
        err_count <= err_count + 1'b1;
    end
  end

`ifdef PRBS_CHK_LOSS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      win  <= '0;
      werr <= '0;
    end else begin
      win  <= win_nxt;
      werr <= werr_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_prbs16_checker.sv
// Scoreboard bench for prbs16_checker: stimulus pushes expected outputs, a monitor pops and compares.
// Honours PRBS_CHK_LOSS_EN the same way as the design.
module tb_prbs16_checker;

  localparam int CW     = 4;
  localparam int WIN    = 64;
  localparam int THRESH = 8;
  localparam int CMAX   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, enable, in_bit, resync, clear_count;
  logic          locked, err;
  logic [CW-1:0] err_count;

  prbs16_checker #(.ERR_CNT_W(CW), .WINDOW(WIN), .LOSS_THRESH(THRESH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_bit(in_bit), .resync(resync),
    .clear_count(clear_count), .locked(locked), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct { bit e; bit l; int c; } exp_t;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // Generator: bit history, oldest first; next bit is b[n-16]^b[n-14]^b[n-13]^b[n-11]
  bit gq[$];
  function automatic bit gen_next();
    bit b = gq[0] ^ gq[2] ^ gq[3] ^ gq[5];
    void'(gq.pop_front());
    gq.push_back(b);
    return b;
  endfunction

  // Reference model: mode 0 search, 1 verify, 2 locked; mh holds the last 16 local bits
  bit mh[$];
  int mmode, mcnt, mwin, mwerr, mec;

  function automatic void mshift(bit b);
    void'(mh.pop_front());
    mh.push_back(b);
  endfunction

  function automatic exp_t model_step(bit rst, bit en, bit ib, bit rs, bit clr);
    exp_t r;
    bit pr;
    int ones;
    r.e = 0;
    if (rst) begin
      mh = {};
      repeat (16) mh.push_back(1'b0);
      mmode = 0; mcnt = 0; mwin = 0; mwerr = 0; mec = 0;
    end else begin
      if (rs) begin
        mmode = 0; mcnt = 0; mwin = 0; mwerr = 0;
      end else if (en) begin
        pr = mh[0] ^ mh[2] ^ mh[3] ^ mh[5];
        if (mmode == 0) begin
          mshift(ib);
          mcnt++;
          if (mcnt == 16) begin
            mcnt = 0;
            ones = 0;
            foreach (mh[i]) ones += int'(mh[i]);
            if (ones > 0) mmode = 1;
          end
        end else if (mmode == 1) begin
          mshift(ib);
          if (ib != pr) begin
            mmode = 0; mcnt = 0;
          end else begin
            mcnt++;
            if (mcnt == 16) begin
              mmode = 2; mcnt = 0; mwin = 0; mwerr = 0;
            end
          end
        end else begin
          mshift(pr);
          if (ib != pr) begin
            r.e = 1;
            if (mec < CMAX) mec++;
          end
`ifdef PRBS_CHK_LOSS_EN
          if (ib != pr) mwerr++;
          if (ib != pr && mwerr >= THRESH) begin
            mmode = 0; mcnt = 0; mwin = 0; mwerr = 0;
          end else if (mwin == WIN - 1) begin
            mwin = 0; mwerr = 0;
          end else begin
            mwin++;
          end
`endif
        end
      end
      if (clr) mec = 0;
    end
    r.l = (mmode == 2);
    r.c = mec;
    return r;
  endfunction

  task automatic cyc(input bit rst, input bit en, input bit flip, input bit rs,
                     input bit clr, input bit zero);
    bit b;
    @(negedge clk);
    b = en ? gen_next() : 1'($urandom);
    if (flip) b = ~b;
    if (zero) b = 1'b0;
    reset = rst; enable = en; in_bit = b; resync = rs; clear_count = clr;
    sb.push_back(model_step(rst, en, b, rs, clr));
  endtask

  task automatic clean(input int n);
    repeat (n) cyc(0, 1, 0, 0, 0, 0);
  endtask

  // Monitor: outputs after each edge correspond to the oldest queued expectation
  initial begin
    exp_t r;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        r = sb.pop_front();
        vectors++;
        if (err !== r.e || locked !== r.l || int'(err_count) != r.c || $isunknown(err_count)) begin
          miscompares++;
          $display("FAIL outputs t=%0t: err=%b locked=%b err_count=%0d, required err=%b locked=%b err_count=%0d",
                   $time, err, locked, err_count, r.e, r.l, r.c);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; in_bit = 1'b0; resync = 1'b0; clear_count = 1'b0;
    repeat (15) gq.push_back(1'b0);
    gq.push_back(1'b1);

    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    clean(200);
    clean(30);
    cyc(0, 1, 1, 0, 0, 0);
    clean(50);
    for (int i = 0; i < 40; i++) cyc(0, 1, (i % 5) == 0, 0, 0, 0);
    clean(80);
    repeat (100) cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 1, 0, 0);
    repeat (100) cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 140; i++) cyc(0, (i % 2) == 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    clean(20);
    cyc(0, 1, 1, 0, 0, 0);
    clean(60);
    cyc(0, 1, 1, 0, 1, 0);
    clean(10);
    cyc(0, 1, 0, 1, 0, 0);
    clean(40);
    cyc(1, 1, 0, 0, 0, 0);
    clean(40);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 999) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
          $urandom_range(0, 499) == 0, $urandom_range(0, 299) == 0, 0);

    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prbs16_checker.md
# prbs16_checker

Serial PRBS-16 checker: the receive end of the team's 16-bit Fibonacci LFSR pattern generator (polynomial x^16+x^14+x^13+x^11+1). It self-synchronises to an incoming bit stream, verifies lock, then flags and counts every mismatched bit. It sits after a serialiser or loopback path for link BIST and SoC bring-up.

## Interface
- ERR_CNT_W, 16: width of the saturating error counter.
- WINDOW, 64: lock-loss observation window in locked bits; power of two, ≥ 16.
- LOSS_THRESH, 8: errors within one window that force loss of lock; 1 ≤ LOSS_THRESH ≤ WINDOW.
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  bit-valid strobe; `in_bit` is consumed only on cycles where `enable` = 1.
- in_bit  input  1  received serial bit.
- resync  input  1  single-cycle request to drop lock and restart search.
- clear_count  input  1  synchronous clear of `err_count`.
- locked  output  1  high while in LOCKED.
- err  output  1  one-cycle pulse for a mismatched bit in LOCKED.
- err_count  output  ERR_CNT_W  total mismatches in LOCKED; saturating.

## Operation
- Local 16-bit register `s`. Predicted bit: `p = s[15]^s[13]^s[12]^s[10]`. The generator emits exactly `p` as its next serial bit.
- Every accepted bit shifts in: `s <= {s[14:0], x}`.
  - In SEARCH and VERIFY, x = `in_bit`.
  - In LOCKED, x = `p`. Received errors never corrupt the local state, so one flipped bit gives exactly one `err`.
- State machine, one state per accepted bit:
  - SEARCH: fill counter 0..15 counts accepted bits. After the 16th bit:
    - `s` nonzero → VERIFY, verify counter cleared.
    - `s` all zero → stay in SEARCH, fill counter restarts.
  - VERIFY: compare `in_bit` with `p`.
    - Mismatch → SEARCH, fill counter cleared. No `err` and no count.
    - After 16 consecutive matches → LOCKED.
  - LOCKED: a mismatch raises `err` and increments `err_count` (saturates at all ones). Window logic is in Configuration.
- `resync` = 1 → SEARCH next cycle with all counters except `err_count` cleared. This applies in any state, regardless of `enable`, and overrides the bit accepted that cycle.
- `clear_count` = 1 → `err_count` = 0 next cycle. If a counted error occurs in the same cycle, clear wins and the result is 0.
- `enable` = 0: state, `s` and counters hold, and `err` = 0.

## Timing
- Reset values: state SEARCH, `s` = 0, all internal counters 0, `locked` = 0, `err` = 0, `err_count` = 0.
- Reset takes priority over every other input. Reset during LOCKED returns to SEARCH next cycle and clears `err_count`.
- All outputs are registered.
  - `err` and the `err_count` update appear the cycle after the accepting edge for the offending bit.
  - `locked` rises the cycle after the 32nd consecutive accepted bit of a clean stream (16 fill + 16 verify).
- `locked` falls the cycle after the edge that takes the FSM out of LOCKED, whether by loss, `resync` or reset.
- Throughput is one bit per cycle with no bubbles. `enable` may toggle every cycle.

## Configuration
- `PRBS_CHK_LOSS_EN` defined: lock-loss detection is compiled in.
  - Window counter counts accepted LOCKED bits, modulo WINDOW.
  - Window error counter counts mismatches within the window.
  - If the window error count including the current bit reaches LOSS_THRESH: that bit still pulses `err` and counts, and the FSM → SEARCH.
  - On the bit where the window counter = WINDOW−1, the window error counter clears after that bit is evaluated.
- `PRBS_CHK_LOSS_EN` undefined: no window logic. Once locked, the checker stays LOCKED until `resync` or reset, and counts every error.

## Test plan
- Generator stream seeded 16'h0001, `enable` held high for 200 bits → `locked` rises the cycle after bit 32; `err` never pulses; `err_count` = 0.
- Locked stream with bit 100 inverted → exactly one `err` pulse, one cycle after that bit is accepted; `err_count` = 1; `locked` stays 1; later bits error-free.
- `PRBS_CHK_LOSS_EN` defined, 8 inverted bits within 64 locked bits → 8 `err` pulses, `err_count` = 8; `locked` low the cycle after the 8th. With the macro undefined, `locked` stays high.
- Constant-0 input for 100 bits → `locked` never asserts; FSM stays in SEARCH.
- Clean stream with `enable` toggled 1/0 every cycle → lock after 32 accepted bits (about 64 cycles); no `err`. An error bit during VERIFY → back to SEARCH, lock re-acquired 32 accepted bits later.
- Two edge cases, each while locked:
  - `clear_count` in the same cycle as an error → `err_count` = 0.
  - `resync` pulse → `locked` low next cycle, re-lock after 32 bits.
